// File: rtl/wb_regfile.sv
// wb_regfile: 31 x 32-bit general-purpose register file fed by the writeback stage.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active low
//   wb_alu_in        ALU result from the ME/WB pipeline register
//   wb_mem_in        load data from the ME/WB pipeline register
//   wb_rd_in         destination register number
//   Ctrl_Mem2Reg_in  1 selects wb_mem_in, 0 selects wb_alu_in
//   Ctrl_regWr_in    writeback write enable
//   rs_addr/rt_addr  ID-stage read addresses
//   rs_data/rt_data  combinational read data (0 for r0 and while in reset)
//   wb_data_out      combinational selected writeback value (EX forwarding)
//   wr_count         registered count of committed register writes (wraps)
//
// Configuration
//   WB_REGFILE_BYPASS_EN  when defined, a read of the register being written
//                         this cycle returns the incoming value (write-through).
//                         When undefined, the read returns the pre-edge contents.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_alu_in,
  input  logic [31:0] wb_mem_in,
  input  logic [4:0]  wb_rd_in,
  input  logic        Ctrl_Mem2Reg_in,
  input  logic        Ctrl_regWr_in,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data_out,
  output logic [31:0] wr_count
);

  // Entry 0 is never written, so it stays at its reset value and is
  // optimised away; reads of r0 are forced to 0 explicitly anyway.
  logic [31:0] regs_q [0:31];
  logic [31:0] regs_d [0:31];
  logic [31:0] wr_count_q, wr_count_d;
  logic        wr_eff;

  assign wb_data_out = Ctrl_Mem2Reg_in ? wb_mem_in : wb_alu_in;
  assign wr_eff      = Ctrl_regWr_in && (wb_rd_in != 5'd0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_eff) begin
      regs_d[wb_rd_in] = wb_data_out;
      wr_count_d       = wr_count_q + 32'd1;  // natural wrap at 2^32
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read port: reset and r0 win over everything, including the bypass match.
  function automatic logic [31:0] rd_port(input logic [4:0] a);
    logic [31:0] v;
    v = regs_q[a];
`ifdef WB_REGFILE_BYPASS_EN
    if (wr_eff && (wb_rd_in == a)) v = wb_data_out;
`endif
    if (!rst || (a == 5'd0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rs_data = rd_port(rs_addr);
    rt_data = rd_port(rt_addr);
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a behavioural array/counter model is
// checked against the DUT on every falling clock edge, plus literal
// expectations for the directed scenarios.
module tb_wb_regfile;
  logic        clk, rst;
  logic [31:0] wb_alu_in, wb_mem_in;
  logic [4:0]  wb_rd_in;
  logic        Ctrl_Mem2Reg_in, Ctrl_regWr_in;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data_out, wr_count;

  int n_chk = 0;
  int n_err = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_alu_in(wb_alu_in), .wb_mem_in(wb_mem_in), .wb_rd_in(wb_rd_in),
    .Ctrl_Mem2Reg_in(Ctrl_Mem2Reg_in), .Ctrl_regWr_in(Ctrl_regWr_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data_out(wb_data_out), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] mregs [0:31];
  logic [31:0] mcnt;
  logic [31:0] cnt_off;   // offset applied when the DUT counter is forced

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 32'd0;
    end else if (Ctrl_regWr_in && wb_rd_in != 5'd0) begin
      mregs[wb_rd_in] = Ctrl_Mem2Reg_in ? wb_mem_in : wb_alu_in;
      mcnt = mcnt + 32'd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (Ctrl_regWr_in && wb_rd_in != 5'd0 && wb_rd_in == a)
      return Ctrl_Mem2Reg_in ? wb_mem_in : wb_alu_in;
`endif
    return mregs[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous compare away from the active edge.
  always @(negedge clk) begin
    chk("cmp_rs",  rs_data,     exp_rd(rs_addr));
    chk("cmp_rt",  rt_data,     exp_rd(rt_addr));
    chk("cmp_wb",  wb_data_out, Ctrl_Mem2Reg_in ? wb_mem_in : wb_alu_in);
    chk("cmp_cnt", wr_count,    mcnt + cnt_off);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                    input logic m2r, input logic we);
    wb_rd_in = rd; wb_alu_in = alu; wb_mem_in = mem;
    Ctrl_Mem2Reg_in = m2r; Ctrl_regWr_in = we;
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    rs_addr = a; rt_addr = b;
  endtask

  initial begin
    rst = 1'b0; cnt_off = 32'd0;
    wr(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rd2(5'd3, 5'd0);
    tick(); tick();
    chk("reset_cnt", wr_count, 32'd0);
    chk("reset_rs",  rs_data,  32'd0);

    // Write presented during reset is dropped.
    wr(5'd3, 32'h0000AAAA, 32'd0, 1'b0, 1'b1);
    tick();
    chk("rst_drop_cnt", wr_count, 32'd0);
    rst = 1'b1;
    Ctrl_regWr_in = 1'b0;
    #1 chk("rst_drop_r3", rs_data, 32'd0);
    tick();

    // r5 <= 0x12345678, read back the next cycle.
    wr(5'd5, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b1);
    rd2(5'd5, 5'd1);
    tick();
    Ctrl_regWr_in = 1'b0;
    #1;
    chk("r5_read", rs_data,  32'h12345678);
    chk("r5_cnt",  wr_count, 32'd1);

    // Writes to r0 are ignored and not counted.
    wr(5'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1);
    rd2(5'd0, 5'd0);
    tick();
    #1;
    chk("r0_read", rs_data,  32'd0);
    chk("r0_cnt",  wr_count, 32'd1);

    // r7 <= mem 0xDEADBEEF with same-cycle read.
    wr(5'd7, 32'h11111111, 32'hDEADBEEF, 1'b1, 1'b1);
    rd2(5'd7, 5'd5);
    #1;
    chk("r7_wbout", wb_data_out, 32'hDEADBEEF);
`ifdef WB_REGFILE_BYPASS_EN
    chk("r7_same", rs_data, 32'hDEADBEEF);
`else
    chk("r7_same", rs_data, 32'h00000000);
`endif
    tick();
    Ctrl_regWr_in = 1'b0;
    #1;
    chk("r7_next", rs_data,  32'hDEADBEEF);
    chk("r7_cnt",  wr_count, 32'd2);

    // r9 <= 0x0000ABCD, read on both ports.
    wr(5'd9, 32'h0000ABCD, 32'd0, 1'b0, 1'b1);
    tick();
    Ctrl_regWr_in = 1'b0;
    rd2(5'd9, 5'd9);
    #1;
    chk("r9_rs", rs_data, 32'h0000ABCD);
    chk("r9_rt", rt_data, 32'h0000ABCD);
    chk("r9_cnt", wr_count, 32'd3);

    // Data changes mid-cycle: only the value at the edge is captured.
    wr(5'd10, 32'h00001111, 32'd0, 1'b0, 1'b1);
    rd2(5'd10, 5'd9);
    #6 wb_alu_in = 32'h00002222;
    tick();
    Ctrl_regWr_in = 1'b0;
    #1 chk("r10_edge", rs_data, 32'h00002222);

    // Write enable low: no update, no count.
    wr(5'd11, 32'h55555555, 32'd0, 1'b0, 1'b0);
    rd2(5'd11, 5'd10);
    tick();
    #1;
    chk("r11_nowe", rs_data,  32'd0);
    chk("r11_cnt",  wr_count, 32'd4);

    // Directed mix, checked by the continuous compare.
    wr(5'd31, 32'h80000001, 32'h0F0F0F0F, 1'b1, 1'b1); rd2(5'd31, 5'd7);  tick();
    wr(5'd1,  32'h00000001, 32'hFFFF0000, 1'b0, 1'b1); rd2(5'd31, 5'd1);  tick();
    wr(5'd31, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b1); rd2(5'd1,  5'd31); tick();
    wr(5'd2,  32'h0,        32'h13579BDF, 1'b1, 1'b0); rd2(5'd2,  5'd31); tick();
    wr(5'd0,  32'h0,        32'h24681ACE, 1'b1, 1'b1); rd2(5'd0,  5'd2);  tick();
    Ctrl_regWr_in = 1'b0; rd2(5'd31, 5'd1);
    #1;
    chk("r31_last", rs_data,  32'hA5A5A5A5);
    chk("r1_val",   rt_data,  32'h00000001);
    chk("mix_cnt",  wr_count, 32'd7);

    // Counter wrap: force to all-ones, then one effective write.
    force dut.wr_count_q = 32'hFFFFFFFF;
    cnt_off = 32'hFFFFFFFF - mcnt;
    #1 release dut.wr_count_q;
    #1 chk("wrap_pre", wr_count, 32'hFFFFFFFF);
    wr(5'd12, 32'h0000C0DE, 32'd0, 1'b0, 1'b1);
    tick();
    Ctrl_regWr_in = 1'b0;
    #1 chk("wrap_zero", wr_count, 32'd0);
    tick();

    // Asynchronous reset mid-cycle after writes.
    rd2(5'd9, 5'd31);
    wr(5'd0, 32'h77777777, 32'h88888888, 1'b1, 1'b0);
    #1;
    rst = 1'b0; cnt_off = 32'd0;
    #1;
    chk("arst_rs",  rs_data,     32'd0);
    chk("arst_rt",  rt_data,     32'd0);
    chk("arst_cnt", wr_count,    32'd0);
    chk("arst_wb",  wb_data_out, 32'h88888888);
    tick();
    // Release with a write pending: accepted on the first edge after release.
    rst = 1'b1;
    wr(5'd9, 32'h00000042, 32'd0, 1'b0, 1'b1);
    rd2(5'd9, 5'd31);
    tick();
    Ctrl_regWr_in = 1'b0;
    #1;
    chk("post_rst_r9",  rs_data,  32'h00000042);
    chk("post_rst_r31", rt_data,  32'd0);
    chk("post_rst_cnt", wr_count, 32'd1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port wb_alu_in, input, 32 bits: ALU result from the ME/WB pipeline register.
REQ-004 SHALL have port wb_mem_in, input, 32 bits: load data from the ME/WB pipeline register.
REQ-005 SHALL have port wb_rd_in, input, 5 bits: destination register number.
REQ-006 SHALL have port Ctrl_Mem2Reg_in, input, 1 bit: 1 selects wb_mem_in, 0 selects wb_alu_in.
REQ-007 SHALL have port Ctrl_regWr_in, input, 1 bit: write enable for this writeback.
REQ-008 SHALL have ports rs_addr and rt_addr, input, 5 bits each: ID-stage read addresses.
REQ-009 SHALL have ports rs_data and rt_data, output, 32 bits each: combinational read data.
REQ-010 SHALL have port wb_data_out, output, 32 bits: combinational selected writeback value, for EX forwarding.
REQ-011 SHALL have port wr_count, output, 32 bits: registered count of committed register writes.

Function
REQ-012 SHALL drive wb_data_out = Ctrl_Mem2Reg_in ? wb_mem_in : wb_alu_in, in the same cycle (zero latency).
REQ-013 SHALL define an effective write as: Ctrl_regWr_in = 1 and wb_rd_in != 0.
REQ-014 SHALL, on each rising clk edge with rst = 1 and an effective write, store wb_data_out into register[wb_rd_in].
REQ-015 SHALL ignore writes to register 0; register 0 SHALL always read 0.
REQ-016 SHALL read rs_data and rt_data combinationally from the array, with 0 returned for address 0.
REQ-017 SHALL, when rs_addr = rt_addr, return identical data on both ports.
REQ-018 SHALL increment wr_count by 1 on each effective write and hold it otherwise.
REQ-019 SHALL wrap wr_count from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-020 SHALL not increment wr_count for a write to register 0, or when Ctrl_regWr_in = 0.
REQ-021 SHALL leave the array unchanged when Ctrl_regWr_in = 1 and a data input changes mid-cycle: only the value present at the edge is captured.

Reset
REQ-022 SHALL, while rst = 0, immediately clear all 31 writable registers and wr_count to 0, independent of clk.
REQ-023 SHALL drive rs_data = 0 and rt_data = 0 while rst = 0; wb_data_out stays combinational.
REQ-024 SHALL drop any write presented on a clk edge while rst = 0; the first write is accepted on the first rising edge after rst returns to 1.

Configuration
REQ-025 SHALL, when macro WB_REGFILE_BYPASS_EN is defined, return wb_data_out on rs_data when there is an effective write and wb_rd_in = rs_addr in the same cycle (write-through); rt_data SHALL behave the same way.
REQ-026 SHALL, without WB_REGFILE_BYPASS_EN, return the pre-edge array contents in that case; the new value SHALL be visible from the cycle after the edge.
REQ-027 SHALL keep register 0 reading 0 under both settings, including when bypass would otherwise match.

Verification
REQ-028 SHALL cover this scenario: rst pulse low mid-cycle after writes -> all reads 0 and wr_count = 0 immediately, without waiting for a clk edge.
REQ-029 SHALL cover this scenario: write rd = 5, alu = 0x12345678, Mem2Reg = 0, then on the next cycle rs_addr = 5 -> rs_data = 0x12345678 and wr_count = 1.
REQ-030 SHALL cover this scenario: write rd = 0, alu = 0xFFFFFFFF, regWr = 1 -> rs_addr = 0 reads 0 and wr_count is unchanged.
REQ-031 SHALL cover this scenario: rd = 7, mem = 0xDEADBEEF, Mem2Reg = 1, rs_addr = 7 in the same cycle -> rs_data = 0xDEADBEEF with the macro, the old value 0 without it, and 0xDEADBEEF on the next cycle in both builds.
REQ-032 SHALL cover this scenario: wr_count preset to 0xFFFFFFFF via 2^32 - 1 writes or forced, then one effective write -> wr_count = 0.
REQ-033 SHALL cover this scenario: rs_addr = rt_addr = 9 after writing 0x0000ABCD -> both ports read 0x0000ABCD.
